sigmoid_pwl_pipe: RTL

- Streaming, pipelined piecewise-linear activation unit for the embedded NN datapath.
- Generalises the combinational sigmoid approximation in three ways:
  - parametrised input and output fixed-point formats;
  - a per-sample mode selecting sigmoid or tanh;
  - valid/ready handshaking with full backpressure and a sideband tag carried alongside each sample.
- Sits between the neuron accumulator and the layer output buffer.

---
 rtl/sigmoid_pwl_pipe.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sigmoid_pwl_pipe.sv
// Three-stage streaming piecewise-linear sigmoid/tanh unit with valid/ready flow control.
// S1 folds the sign and selects a segment, S2 evaluates the shift-add segment, S3 applies sign/mode.
module sigmoid_pwl_pipe #(
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 24,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 14,
  parameter int TAG_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_mode,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int F_W = FRAC_W + 2;
  localparam int R_W = FRAC_W + 3;
  localparam int SH  = FRAC_W - OUT_FRAC;

  localparam logic [DATA_W-1:0] U_ONE   = DATA_W'(1) << FRAC_W;
  localparam logic [DATA_W-1:0] U_2P375 = DATA_W'(19) << (FRAC_W - 3);
  localparam logic [DATA_W-1:0] U_2P5   = DATA_W'(5) << (FRAC_W - 1);
  localparam logic [DATA_W-1:0] U_5     = DATA_W'(5) << FRAC_W;
  localparam logic [DATA_W-1:0] U_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] U_MAX   = {1'b0, {(DATA_W-1){1'b1}}};

  localparam logic [F_W-1:0] F_ONE = F_W'(1) << FRAC_W;
  localparam logic [F_W-1:0] F_C0  = F_W'(1) << (FRAC_W - 1);
  localparam logic [F_W-1:0] F_C1  = F_W'(5) << (FRAC_W - 3);
  localparam logic [F_W-1:0] F_C2  = F_W'(27) << (FRAC_W - 5);

  localparam logic signed [R_W-1:0] R_ONE = R_W'(1) << FRAC_W;

  // Magnitude with the most-negative code pinned to the largest positive value,
  // which lands in the flat region for both modes.
  function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] ux;
    ux = x;
    if (ux == U_MIN)
      return U_MAX;
    else if (x < 0)
      return DATA_W'(-x);
    else
      return ux;
  endfunction

  function automatic logic [1:0] region_of(input logic [DATA_W-1:0] u);
    if (u < U_ONE)
      return 2'd0;
    else if (u < U_2P375)
      return 2'd1;
    else if (u < U_5)
      return 2'd2;
    else
      return 2'd3;
  endfunction

  function automatic logic [OUT_W-1:0] floor_out(input logic signed [R_W-1:0] r);
    logic signed [R_W-1:0] q;
    q = r >>> SH;
    return OUT_W'(q);
  endfunction

  logic ld_p0, ld_p1, ld_p2;
  logic vld_p0, vld_p1, vld_p2;

  logic              sign_p0, mode_p0;
  logic [TAG_W-1:0]  tag_p0;
  logic [DATA_W-1:0] u_p0;
  logic [1:0]        reg_p0;

  logic              sign_p1, mode_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic [F_W-1:0]    f_p1;

  logic [OUT_W-1:0]  data_p2;
  logic              mode_p2;
  logic [TAG_W-1:0]  tag_p2;

  logic signed [DATA_W-1:0] x_in;
  logic [DATA_W-1:0]        a_in, u_in;
  logic [F_W-1:0]           f_nxt;
  logic signed [R_W-1:0]    fs, t_nxt, r_nxt;

  // A stage loads when empty or when its occupant moves on this cycle.
  assign ld_p2    = !vld_p2 || out_ready;
  assign ld_p1    = !vld_p1 || ld_p2;
  assign ld_p0    = !vld_p0 || ld_p1;
  assign in_ready = ld_p0;

  assign busy      = vld_p0 | vld_p1 | vld_p2;
  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_mode  = mode_p2;
  assign out_tag   = tag_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (ld_p0) vld_p0 <= in_valid;
      if (ld_p1) vld_p1 <= vld_p0;
      if (ld_p2) vld_p2 <= vld_p1;
    end
  end

  // ---- S1: fold sign, pre-scale for tanh, select segment ----
  always_comb begin
    x_in = $signed(in_data);
    a_in = abs_sat(x_in);
    u_in = a_in;
    if (in_mode)
      u_in = (a_in >= U_2P5) ? U_5 : (a_in << 1);
  end

  always_ff @(posedge clk) begin
    if (ld_p0 && in_valid) begin
      sign_p0 <= in_data[DATA_W-1];
      mode_p0 <= in_mode;
      tag_p0  <= in_tag;
      u_p0    <= u_in;
      reg_p0  <= region_of(u_in);
    end
  end

  // ---- S2: shift-add segment evaluation, truncating shifted-out bits ----
  always_comb begin
    f_nxt = F_ONE;
    case (reg_p0)
      2'd0:    f_nxt = F_W'(u_p0 >> 2) + F_C0;
      2'd1:    f_nxt = F_W'(u_p0 >> 3) + F_C1;
      2'd2:    f_nxt = F_W'(u_p0 >> 5) + F_C2;
      default: f_nxt = F_ONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ld_p1 && vld_p0) begin
      sign_p1 <= sign_p0;
      mode_p1 <= mode_p0;
      tag_p1  <= tag_p0;
      f_p1    <= f_nxt;
    end
  end

  // ---- S3: mirror for negative inputs, map to tanh, floor to output format ----
  always_comb begin
    fs    = $signed(R_W'(f_p1));
    t_nxt = (fs <<< 1) - R_ONE;
    if (mode_p1)
      r_nxt = sign_p1 ? -t_nxt : t_nxt;
    else
      r_nxt = sign_p1 ? (R_ONE - fs) : fs;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_p2 <= '0;
      mode_p2 <= 1'b0;
      tag_p2  <= '0;
    end else if (ld_p2 && vld_p1) begin
      data_p2 <= floor_out(r_nxt);
      mode_p2 <= mode_p1;
      tag_p2  <= tag_p1;
    end
  end

endmodule
